piano_keypad_poly: RTL and testbench
====================================

# piano_keypad_poly

Polyphonic successor to the single-voice keypad decoder. Accepts press/release events from the keypad scanner, maps keycodes to chromatic notes, and allocates them across `VOICES` independent note/octave channels, with oldest-voice stealing when all are busy. Sits between the keypad scanner and the per-voice tone generators; each voice slot drives one tone channel.

## Interface
Parameters:
- `VOICES`, 4: number of voice slots (1..8).
- `KEY_W`, 5: keycode width.
- `OCT_MIN`, 0: lowest octave.
- `OCT_MAX`, 9: highest octave.
- `OCT_INIT`, 4: octave after reset.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle event strobe.
- `key_release`  in  1  qualifies the event: 0 = press, 1 = release.
- `keycode`  in  `KEY_W`  key identifier, valid with `key_valid`.
- `notes`  out  `4*VOICES`  voice i note at `[4i+3:4i]`: 0 = rest, 1..12 = C..B.
- `octaves`  out  `4*VOICES`  voice i octave, latched at allocation.
- `voice_active`  out  `VOICES`  voice i holds a sounding key.
- `octave`  out  4  current global octave.
- `overflow`  out  1  one-cycle pulse when a press steals a busy voice.

## Operation
- Note keymap:
  - 4 = C(1), 8 = C#(2), 5 = D(3), 9 = D#(4), 6 = E(5), 7 = F(6), 11 = F#(7), 12 = G(8), 16 = G#(9), 13 = A(10), 17 = A#(11), 14 = B(12).
  - 15 = octave up; 19 = octave down.
  - All other keycodes are ignored: no state change.
- Octave keys act on press only; their releases are ignored.
  - The octave saturates at `OCT_MAX` and `OCT_MIN`.
  - An octave change affects only later allocations; sounding voices keep their latched octave.
- Per voice, the block stores: active, keycode, note, octave, and age (`$clog2(VOICES)` bits, saturating at `VOICES-1`).
- Press of a note key:
  - If any active voice already holds that keycode, the press is ignored.
  - Otherwise, allocate the lowest-index inactive voice.
  - If none is inactive, steal the voice with the largest age (ties go to the lowest index) and pulse `overflow`.
  - The allocated voice gets the note, the current `octave`, and age 0. Every other active voice's age increments.
- Release of a note key: the voice holding that keycode goes inactive. A release with no matching voice is ignored.
- An inactive voice drives note 0. Its `octaves` field holds its last value.
- Pipeline: stage 1 registers the event and the decoded note. Stage 2 performs allocation/release against the registered voice state.
  - One event is accepted per cycle with no back-pressure.
  - Consecutive events are applied strictly in order. Each stage-2 event sees all earlier events' effects.

## Timing
- When `key_valid` is high at edge N, the voice outputs, `octave` and `overflow` update at edge N+2. Latency is 2 cycles and throughput is 1 event/cycle.
- `overflow` is high for exactly the cycle after edge N+2, aligned with the stolen voice's new contents.
- Reset values:
  - `notes` = 0, `voice_active` = 0, all ages = 0.
  - `octaves` = `OCT_INIT` in every field; `octave` = `OCT_INIT`.
  - `overflow` = 0; pipeline valid bits = 0.
- `rst` asserted mid-stream discards events in flight. Events strobed in the reset cycle are lost.
- Boundary cases:
  - A press and a release of the same key on consecutive cycles leave the voice inactive.
  - A release followed by a press on consecutive cycles reallocates that key.

## Configuration
- `PIANO_KEYPAD_SUSTAIN_EN` defined:
  - Adds input port `sustain` (1 bit, after `keycode`) and one pending-release bit per voice.
  - A release while `sustain` = 1 sets pending instead of freeing the voice; the voice stays active and its note unchanged.
  - A re-press of a pending key clears pending, with no new allocation.
  - A falling edge of `sustain` frees all pending voices 1 cycle after the sampled low.
  - Stealing treats pending voices like active ones. Reset clears pending.
- Undefined: no `sustain` port; releases free voices immediately as above.

## Test plan
- Reset, then press 4, 5, 6 on cycles 0-2 -> by cycle 4: `voice_active` = 0111; notes 1,3,5; all octaves 4; `overflow` never pulses.
- With `VOICES` = 4: press 4, 5, 6, 7, then 12 -> voice 0 (oldest) is reassigned note 8; `overflow` pulses one cycle; `voice_active` = 1111.
- Press 15 six times, then press 13 -> `octave` = 9 (saturated); the new voice has note 10, octave 9. Press 19 ten times -> `octave` = 0.
- Press 4, press 4 again, release 4 -> only one voice is ever allocated; it is inactive with note 0 two cycles after the release.
- Release 14 with no voice holding it, and press keycode 3 -> no output change.
- With `PIANO_KEYPAD_SUSTAIN_EN`: sustain = 1, press 4, release 4 -> voice stays active with note 1. Drop sustain -> inactive one cycle later.

Source files
------------

// File: rtl/piano_keypad_poly.sv
// Polyphonic keypad decoder: keycode -> note mapping, voice allocation with oldest-voice stealing.
// Optional sustain pedal behaviour is enabled by defining PIANO_KEYPAD_SUSTAIN_EN.
module piano_keypad_poly #(
    parameter int VOICES   = 4,
    parameter int KEY_W    = 5,
    parameter int OCT_MIN  = 0,
    parameter int OCT_MAX  = 9,
    parameter int OCT_INIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic                key_release,
    input  logic [KEY_W-1:0]    keycode,
`ifdef PIANO_KEYPAD_SUSTAIN_EN
    input  logic                sustain,
`endif
    output logic [4*VOICES-1:0] notes,
    output logic [4*VOICES-1:0] octaves,
    output logic [VOICES-1:0]   voice_active,
    output logic [3:0]          octave,
    output logic                overflow
);
    localparam int AW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(VOICES - 1);
    localparam logic [3:0] OMIN  = 4'(OCT_MIN);
    localparam logic [3:0] OMAX  = 4'(OCT_MAX);
    localparam logic [3:0] OINIT = 4'(OCT_INIT);

    logic             in_valid, in_release;
    logic [KEY_W-1:0] in_key;
    logic             s1_valid, s1_release, s1_up, s1_dn;
    logic [KEY_W-1:0] s1_key;
    logic [3:0]       s1_note;
    logic [3:0]       dec_note;
    logic             dec_up, dec_dn;

    logic [VOICES-1:0] v_act, n_act;
    logic [KEY_W-1:0]  v_key [VOICES];
    logic [KEY_W-1:0]  n_key [VOICES];
    logic [3:0]        v_note [VOICES];
    logic [3:0]        n_note [VOICES];
    logic [3:0]        v_oct [VOICES];
    logic [3:0]        n_oct [VOICES];
    logic [AW-1:0]     v_age [VOICES];
    logic [AW-1:0]     n_age [VOICES];
    logic [3:0]        oct_r, n_octave;
    logic              ovf_r, n_ovf;
    logic [VOICES-1:0] hit_vec, free_oh, steal_oh, alloc_oh;
    logic [AW-1:0]     best_age;
`ifdef PIANO_KEYPAD_SUSTAIN_EN
    logic              in_sus, s1_sus, sus_d1, sus_d2;
    logic [VOICES-1:0] v_pend, n_pend;
`endif

    always_comb begin
        dec_note = 4'd0;
        dec_up   = 1'b0;
        dec_dn   = 1'b0;
        case (int'(in_key))
            4:  dec_note = 4'd1;
            8:  dec_note = 4'd2;
            5:  dec_note = 4'd3;
            9:  dec_note = 4'd4;
            6:  dec_note = 4'd5;
            7:  dec_note = 4'd6;
            11: dec_note = 4'd7;
            12: dec_note = 4'd8;
            16: dec_note = 4'd9;
            13: dec_note = 4'd10;
            17: dec_note = 4'd11;
            14: dec_note = 4'd12;
            15: dec_up   = 1'b1;
            19: dec_dn   = 1'b1;
            default: ;
        endcase
    end

    // Input capture followed by decode register: events reach the voice state two edges after sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid   <= 1'b0;
            in_release <= 1'b0;
            in_key     <= '0;
            s1_valid   <= 1'b0;
            s1_release <= 1'b0;
            s1_key     <= '0;
            s1_note    <= 4'd0;
            s1_up      <= 1'b0;
            s1_dn      <= 1'b0;
        end else begin
            in_valid   <= key_valid;
            in_release <= key_release;
            in_key     <= keycode;
            s1_valid   <= in_valid;
            s1_release <= in_release;
            s1_key     <= in_key;
            s1_note    <= dec_note;
            s1_up      <= dec_up;
            s1_dn      <= dec_dn;
        end
    end

    always_comb begin
        n_act    = v_act;
        n_key    = v_key;
        n_note   = v_note;
        n_oct    = v_oct;
        n_age    = v_age;
        n_octave = oct_r;
        n_ovf    = 1'b0;
        hit_vec  = '0;
        free_oh  = '0;
        steal_oh = '0;
        alloc_oh = '0;
        best_age = '0;
`ifdef PIANO_KEYPAD_SUSTAIN_EN
        n_pend   = v_pend;
`endif
        for (int i = 0; i < VOICES; i++)
            hit_vec[i] = v_act[i] && (v_key[i] == s1_key);
        for (int i = VOICES - 1; i >= 0; i--)
            if (!v_act[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        // Strict greater-than keeps the lowest index on equal ages.
        steal_oh[0] = 1'b1;
        best_age    = v_age[0];
        for (int i = 1; i < VOICES; i++)
            if (v_age[i] > best_age) begin
                steal_oh    = '0;
                steal_oh[i] = 1'b1;
                best_age    = v_age[i];
            end
        if (s1_valid) begin
            if (s1_up && !s1_release && oct_r < OMAX) n_octave = oct_r + 4'd1;
            if (s1_dn && !s1_release && oct_r > OMIN) n_octave = oct_r - 4'd1;
            if (s1_note != 4'd0) begin
                if (s1_release) begin
                    for (int i = 0; i < VOICES; i++)
                        if (hit_vec[i]) begin
`ifdef PIANO_KEYPAD_SUSTAIN_EN
                            if (s1_sus) n_pend[i] = 1'b1;
                            else begin
                                n_act[i]  = 1'b0;
                                n_note[i] = 4'd0;
                                n_pend[i] = 1'b0;
                            end
`else
                            n_act[i]  = 1'b0;
                            n_note[i] = 4'd0;
`endif
                        end
                end else if (hit_vec == '0) begin
                    alloc_oh = (free_oh != '0) ? free_oh : steal_oh;
                    n_ovf    = (free_oh == '0);
                    for (int i = 0; i < VOICES; i++)
                        if (alloc_oh[i]) begin
                            n_act[i]  = 1'b1;
                            n_key[i]  = s1_key;
                            n_note[i] = s1_note;
                            n_oct[i]  = oct_r;
                            n_age[i]  = '0;
`ifdef PIANO_KEYPAD_SUSTAIN_EN
                            n_pend[i] = 1'b0;
`endif
                        end else if (v_act[i] && v_age[i] != AGE_MAX) begin
                            n_age[i] = v_age[i] + 1'b1;
                        end
                end
`ifdef PIANO_KEYPAD_SUSTAIN_EN
                else n_pend = v_pend & ~hit_vec;
`endif
            end
        end
`ifdef PIANO_KEYPAD_SUSTAIN_EN
        if (sus_d2 && !sus_d1)
            for (int i = 0; i < VOICES; i++)
                if (n_pend[i]) begin
                    n_act[i]  = 1'b0;
                    n_note[i] = 4'd0;
                    n_pend[i] = 1'b0;
                end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_act <= '0;
            oct_r <= OINIT;
            ovf_r <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                v_key[i]  <= '0;
                v_note[i] <= 4'd0;
                v_oct[i]  <= OINIT;
                v_age[i]  <= '0;
            end
        end else begin
            v_act  <= n_act;
            v_key  <= n_key;
            v_note <= n_note;
            v_oct  <= n_oct;
            v_age  <= n_age;
            oct_r  <= n_octave;
            ovf_r  <= n_ovf;
        end
    end

`ifdef PIANO_KEYPAD_SUSTAIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            in_sus <= 1'b0;
            s1_sus <= 1'b0;
            sus_d1 <= 1'b0;
            sus_d2 <= 1'b0;
            v_pend <= '0;
        end else begin
            in_sus <= sustain;
            s1_sus <= in_sus;
            sus_d1 <= sustain;
            sus_d2 <= sus_d1;
            v_pend <= n_pend;
        end
    end
`endif

    always_comb begin
        notes   = '0;
        octaves = '0;
        for (int i = 0; i < VOICES; i++) begin
            notes[4*i +: 4]   = v_note[i];
            octaves[4*i +: 4] = v_oct[i];
        end
        voice_active = v_act;
        octave       = oct_r;
        overflow     = ovf_r;
    end
endmodule

// File: tb/tb_piano_keypad_poly.sv
// Directed bench for piano_keypad_poly: a behavioural voice model pushes per-cycle expected
// outputs into a queue; each entry is popped and compared when its output edge arrives.
module tb_piano_keypad_poly;
    localparam int V  = 4;
    localparam int KW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            key_valid = 1'b0;
    logic            key_release = 1'b0;
    logic [KW-1:0]   keycode = '0;
    logic [4*V-1:0]  notes, octaves;
    logic [V-1:0]    voice_active;
    logic [3:0]      octave;
    logic            overflow;

    piano_keypad_poly #(.VOICES(V), .KEY_W(KW)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_release(key_release),
        .keycode(keycode), .notes(notes), .octaves(octaves),
        .voice_active(voice_active), .octave(octave), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             due;
        logic [4*V-1:0] notes;
        logic [4*V-1:0] octs;
        logic [V-1:0]   act;
        logic [3:0]     oct;
        logic           ovf;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    bit m_act [V];
    int m_key [V];
    int m_note[V];
    int m_oct [V];
    int m_age [V];
    int m_octave;
    bit m_ovf;

    function automatic int dec(int k);
        case (k)
            4: return 1;   8: return 2;   5: return 3;   9: return 4;
            6: return 5;   7: return 6;   11: return 7;  12: return 8;
            16: return 9;  13: return 10; 17: return 11; 14: return 12;
            15: return 100;
            19: return 101;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_act[i] = 0; m_key[i] = 0; m_note[i] = 0; m_oct[i] = 4; m_age[i] = 0;
        end
        m_octave = 4;
        m_ovf = 0;
    endtask

    task automatic model_event(bit rel, int k);
        int d, hit, v, best;
        m_ovf = 0;
        d = dec(k);
        if (d == 100) begin
            if (!rel && m_octave < 9) m_octave++;
        end else if (d == 101) begin
            if (!rel && m_octave > 0) m_octave--;
        end else if (d != 0) begin
            hit = -1;
            for (int i = 0; i < V; i++) if (m_act[i] && m_key[i] == k) hit = i;
            if (rel) begin
                if (hit >= 0) begin m_act[hit] = 0; m_note[hit] = 0; end
            end else if (hit < 0) begin
                v = -1;
                for (int i = 0; i < V; i++) if (!m_act[i] && v < 0) v = i;
                if (v < 0) begin
                    best = 0;
                    for (int i = 1; i < V; i++) if (m_age[i] > m_age[best]) best = i;
                    v = best;
                    m_ovf = 1;
                end
                for (int i = 0; i < V; i++)
                    if (i != v && m_act[i] && m_age[i] < V - 1) m_age[i]++;
                m_act[v] = 1; m_key[v] = k; m_note[v] = d; m_oct[v] = m_octave; m_age[v] = 0;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.due = cyc + 3;
        for (int i = 0; i < V; i++) begin
            e.notes[4*i +: 4] = m_note[i][3:0];
            e.octs[4*i +: 4]  = m_oct[i][3:0];
            e.act[i]          = m_act[i];
        end
        e.oct = m_octave[3:0];
        e.ovf = m_ovf;
        q.push_back(e);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic compare_due();
        exp_t e;
        while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("notes",        32'(notes),        32'(e.notes));
            chk("octaves",      32'(octaves),      32'(e.octs));
            chk("voice_active", 32'(voice_active), 32'(e.act));
            chk("octave",       32'(octave),       32'(e.oct));
            chk("overflow",     32'(overflow),     32'(e.ovf));
        end
    endtask

    task automatic step(bit v, bit rel, int k);
        key_valid   = v;
        key_release = rel;
        keycode     = k[KW-1:0];
        if (v) model_event(rel, k);
        else   m_ovf = 0;
        push_expected();
        @(posedge clk);
        cyc++;
        #1;
        key_valid = 1'b0;
        compare_due();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_notes"},   32'(notes),        32'h0);
        chk({tag, "_octaves"}, 32'(octaves),      32'h4444);
        chk({tag, "_active"},  32'(voice_active), 32'h0);
        chk({tag, "_octave"},  32'(octave),       32'h4);
        chk({tag, "_ovf"},     32'(overflow),     32'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) begin @(posedge clk); cyc++; end
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        step(1, 0, 4); step(1, 0, 5); step(1, 0, 6);
        idle(3);
        step(1, 0, 7); step(1, 0, 12);
        idle(3);
        step(1, 1, 5); step(1, 1, 6); step(1, 1, 7); step(1, 1, 12);
        idle(2);
        for (int i = 0; i < 6; i++) step(1, 0, 15);
        step(1, 1, 15);
        step(1, 0, 13);
        idle(2);
        for (int i = 0; i < 10; i++) step(1, 0, 19);
        step(1, 1, 13);
        idle(2);
        step(1, 0, 4); step(1, 0, 4); step(1, 1, 4);
        idle(3);
        step(1, 1, 14); step(1, 0, 3); step(1, 0, 31);
        idle(3);
        step(1, 0, 9); step(1, 1, 9);
        step(1, 0, 11); step(1, 1, 11); step(1, 0, 11);
        idle(2);
        step(1, 0, 15); step(1, 0, 15);
        step(1, 0, 16); step(1, 0, 17); step(1, 0, 14);
        step(1, 0, 8); step(1, 0, 13); step(1, 1, 17); step(1, 0, 5);
        idle(4);

        step(1, 0, 7);
        rst = 1'b1;
        q.delete();
        repeat (2) begin @(posedge clk); cyc++; end
        #1;
        check_reset_state("midreset");
        model_reset();
        rst = 1'b0;
        idle(3);
        step(1, 0, 6);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
